seq_signed_div_n: RTL
=====================

Name: seq_signed_div_n

Overview:
Sequential two's-complement signed divider, the inverse operation of the combinational signed (Baugh-Wooley) multiplier block. It takes an N-bit signed dividend and divisor and returns an N-bit quotient and remainder. Truncating division: the quotient rounds toward zero and the remainder takes the sign of the dividend. The core is a radix-2 restoring iteration on magnitudes followed by a sign-fix cycle, with a start/busy/done handshake.

Parameters:
N, 4, operand/result width in bits (two's complement); legal N >= 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
a  input  N  signed dividend, captured on the accepting edge
b  input  N  signed divisor, captured on the accepting edge
busy  output  1  operation in progress; start ignored while high
done  output  1  one-cycle pulse; q/r/dbz/ovf valid from this cycle
q  output  N  signed quotient
r  output  N  signed remainder
dbz  output  1  divide-by-zero flag for the last operation
ovf  output  1  quotient overflow flag (a = -2^(N-1), b = -1)

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, dbz, ovf, q, r = 0; internal registers cleared. A reset during an operation abandons it and no done pulse follows.
- States: IDLE, CALC, FIX, DONE.
- IDLE: on a rising edge with start=1 (edge E0):
  - Latch sign_q = a[N-1]^b[N-1] and sign_r = a[N-1].
  - Latch |a| and |b| as N-bit unsigned values (|-2^(N-1)| = 2^(N-1) fits).
  - Clear the (N+1)-bit partial remainder; count=0; busy=1.
  - Clear dbz and ovf. q and r keep their previous values until FIX or DONE writes them.
  - If b==0: go to DONE. Otherwise go to CALC.
- CALC: one quotient bit per edge, N edges (E1..EN):
  - Shift {rem, dividend register} left by 1.
  - Trial = rem - |b|.
  - If the trial is non-negative: rem = trial and the quotient LSB = 1; otherwise the quotient LSB = 0.
  - count increments each edge; leave to FIX after the Nth step.
- FIX: edge E(N+1):
  - q = sign_q ? -qmag : qmag (N-bit wrap). r = sign_r ? -rem : rem.
  - ovf = 1 when a = -2^(N-1) and b = -1; q then wraps to -2^(N-1) and r = 0.
  - Go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle; at the next edge go to IDLE with done=0 and busy=0.
  - Divide-by-zero path: DONE is entered directly from IDLE. In that case q = all ones (-1), r = a, dbz=1, ovf=0.
- Latency:
  - Normal path: done is high in the cycle after edge E(N+1), i.e. N+2 edges from acceptance to IDLE.
  - Zero-divisor path: done is high in the cycle after E0.
- Back-to-back: start may be high in the cycle done=1 but is not accepted (busy=1). It is accepted on the following edge, so the minimum spacing is N+3 cycles.
- start held high continuously: a new operation starts each time the block returns to IDLE.
- a and b are don't-care outside the accepting edge.
- Outputs hold their last results indefinitely while in IDLE.
- Identities for all b != 0 excluding the ovf case:
  - a == q*b + r
  - |r| < |b|
  - r == 0 or sign(r) == sign(a)

Test Plan:
- Reset: assert rst mid-CALC (a=7, b=2, after 2 edges) -> busy=0, done=0, q=0, r=0 immediately; no done pulse; the next start with 7/2 completes normally.
- Signs: 7/2 -> q=3, r=1; -7/2 -> q=-3, r=-1; 7/-2 -> q=-3, r=1; -7/-2 -> q=3, r=-1. done is high exactly once, in the cycle after edge E5 (N=4).
- Overflow and extremes: -8/-1 -> q=-8, r=0, ovf=1; -8/1 -> q=-8, ovf=0; -8/7 -> q=-1, r=-1.
- Divide by zero: 5/0 -> done in the cycle after E0, q=-1, r=5, dbz=1; the next op 6/3 -> dbz=0, q=2, r=0.
- Handshake: start pulsed while busy with a=1, b=1 -> ignored, and the in-flight 7/2 result is unchanged. start held high -> consecutive ops spaced N+3 cycles.
- Exhaustive N=4: all 256 (a,b) pairs via start/done loop. Check the identities above plus the defined ovf/dbz results; require num_wrong = 0.

Source files
------------

// File: rtl/seq_signed_div_n_if.sv
// Start/busy/done handshake and operand/result bus for the sequential signed divider.
interface seq_signed_div_n_if #(
  parameter int unsigned N = 4
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         dbz;
  logic         ovf;

  modport master (output start, a, b, input busy, done, q, r, dbz, ovf);
  modport slave  (input start, a, b, output busy, done, q, r, dbz, ovf);
endinterface

// File: rtl/seq_signed_div_n.sv
// Sequential truncating signed divider: radix-2 restoring on magnitudes, then a sign-fix cycle.
module seq_signed_div_n #(
  parameter int unsigned N = 4
) (
  input  logic                clk,
  input  logic                rst,
  seq_signed_div_n_if.slave   bus
);
  localparam int unsigned CW      = $clog2(N + 1);
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ALL_ONE = {N{1'b1}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  dvd_q, dvd_d;
  logic [N-1:0]  bmag_q, bmag_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;
  logic          ovf_case_q, ovf_case_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  res_r_q, res_r_d;

  logic [N-1:0]  a_mag, b_mag;
  logic [N:0]    shifted;
  logic [N:0]    trial;

  // Registered state and results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dvd_q      <= '0;
      bmag_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      ovf_case_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
      quo_q      <= '0;
      res_r_q    <= '0;
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      bmag_q     <= bmag_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      ovf_case_q <= ovf_case_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
      quo_q      <= quo_d;
      res_r_q    <= res_r_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    bmag_d     = bmag_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    ovf_case_d = ovf_case_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    quo_d      = quo_q;
    res_r_d    = res_r_q;

    a_mag   = bus.a[N-1] ? N'(N'(0) - bus.a) : bus.a;
    b_mag   = bus.b[N-1] ? N'(N'(0) - bus.b) : bus.b;
    // rem < |b| <= 2^(N-1), so the shifted remainder always fits in N+1 bits
    shifted = {rem_q, dvd_q[N-1]};
    trial   = shifted - {1'b0, bmag_q};

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          neg_quo_d  = bus.a[N-1] ^ bus.b[N-1];
          neg_rem_d  = bus.a[N-1];
          ovf_case_d = (bus.a == MIN_VAL) && (bus.b == ALL_ONE);
          dvd_d      = a_mag;
          bmag_d     = b_mag;
          rem_d      = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          dbz_d      = 1'b0;
          ovf_d      = 1'b0;
          if (bus.b == '0) begin
            // Zero divisor: results are defined directly, skip the iteration
            quo_d   = ALL_ONE;
            res_r_d = bus.a;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (shifted >= {1'b0, bmag_q}) begin
          rem_d = trial[N-1:0];
          dvd_d = {dvd_q[N-2:0], 1'b1};
        end else begin
          rem_d = shifted[N-1:0];
          dvd_d = {dvd_q[N-2:0], 1'b0};
        end
        cnt_d = CW'(cnt_q + CW'(1));
        if (cnt_q == CW'(N - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        quo_d   = neg_quo_q ? N'(N'(0) - dvd_q) : dvd_q;
        res_r_d = neg_rem_q ? N'(N'(0) - rem_q) : rem_q;
        ovf_d   = ovf_case_q;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dbz  = dbz_q;
  assign bus.ovf  = ovf_q;
  assign bus.q    = quo_q;
  assign bus.r    = res_r_q;
endmodule
